// File: rtl/eret_controller.sv
// Exception-return sequencer: drains the pipeline, restores SR/mode/PC from the saved copies,
// flushes, then holds stall for a short guard window so the restored masks settle before fetch.
module eret_controller #(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int GUARD_CYCLES  = 2,
  parameter int ALIGN_CHECK   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eret,
  input  logic        mode,
  input  logic        jisr,
  input  logic [31:0] esr_in,
  input  logic [31:0] epc_in,
  input  logic        emode_in,
  input  logic        drain_done,
  output logic        stall,
  output logic        flush,
  output logic        sr_we,
  output logic [31:0] sr_out,
  output logic        mode_we,
  output logic        mode_out,
  output logic        pc_we,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        ill_ret,
  output logic        mis_ret,
  output logic        timeout,
  output logic [1:0]  fsm_state
);

  localparam int MAX_CNT = (DRAIN_TIMEOUT > GUARD_CYCLES) ? DRAIN_TIMEOUT : GUARD_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, RESTORE, GUARD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   gcnt_q, gcnt_d;
  logic [31:0]     esr_q, epc_q;
  logic            emode_q;
  logic            latch;
  logic            ill_d, mis_d, to_d;
  logic            stall_d, strobe_d;
  logic [31:0]     sr_out_d, pc_out_d;
  logic            mode_out_d;

  // State, shadow and output registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      esr_q    <= '0;
      epc_q    <= '0;
      emode_q  <= 1'b0;
      stall    <= 1'b0;
      busy     <= 1'b0;
      flush    <= 1'b0;
      sr_we    <= 1'b0;
      mode_we  <= 1'b0;
      pc_we    <= 1'b0;
      sr_out   <= '0;
      mode_out <= 1'b0;
      pc_out   <= '0;
      ill_ret  <= 1'b0;
      mis_ret  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      if (latch) begin
        esr_q   <= esr_in;
        epc_q   <= epc_in;
        emode_q <= emode_in;
      end
      stall    <= stall_d;
      busy     <= stall_d;
      flush    <= strobe_d;
      sr_we    <= strobe_d;
      mode_we  <= strobe_d;
      pc_we    <= strobe_d;
      sr_out   <= sr_out_d;
      mode_out <= mode_out_d;
      pc_out   <= pc_out_d;
      ill_ret  <= ill_d;
      mis_ret  <= mis_d;
      timeout  <= to_d;
    end
  end

  // Next-state logic; jisr always wins over an in-progress return.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    latch   = 1'b0;
    ill_d   = 1'b0;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (eret && !jisr) begin
          if (mode) begin
            ill_d = 1'b1;
          end else if ((ALIGN_CHECK != 0) && (epc_in[1:0] != 2'b00)) begin
            mis_d = 1'b1;
          end else begin
            latch   = 1'b1;
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (jisr) begin
          state_d = IDLE;
        end else if (drain_done) begin
          state_d = RESTORE;
        end else if (cnt_q == CW'(DRAIN_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESTORE: begin
        if (jisr) begin
          state_d = IDLE;
        end else begin
          gcnt_d  = '0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (jisr || (gcnt_q == CW'(GUARD_CYCLES - 1))) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state and shadow regs.
  always_comb begin
    stall_d    = (state_d != IDLE);
    strobe_d   = (state_d == RESTORE);
    sr_out_d   = sr_out;
    mode_out_d = mode_out;
    pc_out_d   = pc_out;
    if (strobe_d) begin
      sr_out_d   = esr_q;
      mode_out_d = emode_q;
      pc_out_d   = epc_q;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_eret_controller.sv
// Directed bench for eret_controller: basic return, illegal/misaligned erets, drain timeout,
// jisr priority and reset mid-operation, plus a second instance with alignment checking off.
module tb_eret_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        eret, mode, jisr, emode_in, drain_done;
  logic [31:0] esr_in, epc_in;

  logic        stall, flush, sr_we, mode_we, mode_out, pc_we, busy, ill_ret, mis_ret, timeout;
  logic [31:0] sr_out, pc_out;
  logic [1:0]  fsm_state;

  logic        na_stall, na_flush, na_sr_we, na_mode_we, na_mode_out, na_pc_we, na_busy;
  logic        na_ill_ret, na_mis_ret, na_timeout;
  logic [31:0] na_sr_out, na_pc_out;
  logic [1:0]  na_fsm_state;

  int checks   = 0;
  int failures = 0;

  // Flag order: stall busy flush sr_we mode_we pc_we ill_ret mis_ret timeout
  localparam logic [8:0] F_IDLE    = 9'b00_0000_000;
  localparam logic [8:0] F_BUSY    = 9'b11_0000_000;
  localparam logic [8:0] F_RESTORE = 9'b11_1111_000;
  localparam logic [8:0] F_ILL     = 9'b00_0000_100;
  localparam logic [8:0] F_MIS     = 9'b00_0000_010;
  localparam logic [8:0] F_TO      = 9'b00_0000_001;

  logic [8:0] flags, na_flags;
  assign flags    = {stall, busy, flush, sr_we, mode_we, pc_we, ill_ret, mis_ret, timeout};
  assign na_flags = {na_stall, na_busy, na_flush, na_sr_we, na_mode_we, na_pc_we,
                     na_ill_ret, na_mis_ret, na_timeout};

  always #5 clk = ~clk;

  eret_controller #(.DRAIN_TIMEOUT(16), .GUARD_CYCLES(2), .ALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset), .eret(eret), .mode(mode), .jisr(jisr),
    .esr_in(esr_in), .epc_in(epc_in), .emode_in(emode_in), .drain_done(drain_done),
    .stall(stall), .flush(flush), .sr_we(sr_we), .sr_out(sr_out),
    .mode_we(mode_we), .mode_out(mode_out), .pc_we(pc_we), .pc_out(pc_out),
    .busy(busy), .ill_ret(ill_ret), .mis_ret(mis_ret), .timeout(timeout),
    .fsm_state(fsm_state)
  );

  eret_controller #(.DRAIN_TIMEOUT(16), .GUARD_CYCLES(2), .ALIGN_CHECK(0)) u_na (
    .clk(clk), .reset(reset), .eret(eret), .mode(mode), .jisr(jisr),
    .esr_in(esr_in), .epc_in(epc_in), .emode_in(emode_in), .drain_done(drain_done),
    .stall(na_stall), .flush(na_flush), .sr_we(na_sr_we), .sr_out(na_sr_out),
    .mode_we(na_mode_we), .mode_out(na_mode_out), .pc_we(na_pc_we), .pc_out(na_pc_out),
    .busy(na_busy), .ill_ret(na_ill_ret), .mis_ret(na_mis_ret), .timeout(na_timeout),
    .fsm_state(na_fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset = 1'b1; eret = 1'b0; mode = 1'b0; jisr = 1'b0; emode_in = 1'b0;
    drain_done = 1'b0; esr_in = '0; epc_in = '0;
    tick();
    tick();
    check("reset_flags", 32'(flags), 32'(F_IDLE));
    check("reset_sr_out", sr_out, 32'h0);
    check("reset_pc_out", pc_out, 32'h0);
    check("reset_mode_out", 32'(mode_out), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_flags", 32'(flags), 32'(F_IDLE));

    // Basic return; inputs change after latching and must be ignored.
    esr_in = 32'h0000_00FF; epc_in = 32'h0000_1000; emode_in = 1'b1;
    drain_done = 1'b1; eret = 1'b1;
    tick();
    check("basic_drain", 32'(flags), 32'(F_BUSY));
    eret = 1'b0; esr_in = 32'hDEAD_BEEF; epc_in = 32'h0000_2000; emode_in = 1'b0;
    tick();
    check("basic_restore", 32'(flags), 32'(F_RESTORE));
    check("basic_sr_out", sr_out, 32'h0000_00FF);
    check("basic_pc_out", pc_out, 32'h0000_1000);
    check("basic_mode_out", 32'(mode_out), 32'h1);
    tick();
    check("basic_guard0", 32'(flags), 32'(F_BUSY));
    mode = 1'b1; eret = 1'b1;
    tick();
    check("basic_guard1_eret_ignored", 32'(flags), 32'(F_BUSY));
    check("basic_guard_sr_hold", sr_out, 32'h0000_00FF);
    eret = 1'b0; mode = 1'b0;
    tick();
    check("basic_done", 32'(flags), 32'(F_IDLE));
    check("basic_pc_hold", pc_out, 32'h0000_1000);

    // User-mode eret.
    mode = 1'b1; eret = 1'b1;
    tick();
    check("user_ill_ret", 32'(flags), 32'(F_ILL));
    eret = 1'b0; mode = 1'b0;
    tick();
    check("user_after", 32'(flags), 32'(F_IDLE));

    // Misaligned EPC: aborted here, restored by the instance without the check.
    esr_in = 32'h0000_0055; epc_in = 32'h0000_1002; emode_in = 1'b0; eret = 1'b1;
    tick();
    check("mis_pulse", 32'(flags), 32'(F_MIS));
    check("mis_na_drain", 32'(na_flags), 32'(F_BUSY));
    eret = 1'b0;
    tick();
    check("mis_after", 32'(flags), 32'(F_IDLE));
    check("mis_pc_unchanged", pc_out, 32'h0000_1000);
    check("mis_na_restore", 32'(na_flags), 32'(F_RESTORE));
    check("mis_na_pc_out", na_pc_out, 32'h0000_1002);
    tick();
    tick();
    tick();
    check("mis_na_done", 32'(na_flags), 32'(F_IDLE));

    // Drain timeout after exactly 16 cycles.
    drain_done = 1'b0; epc_in = 32'h0000_3000; eret = 1'b1;
    tick();
    check("to_entry", 32'(flags), 32'(F_BUSY));
    eret = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check("to_waiting", 32'(flags), 32'(F_BUSY));
    end
    tick();
    check("to_pulse", 32'(flags), 32'(F_TO));
    tick();
    check("to_after", 32'(flags), 32'(F_IDLE));
    check("to_pc_unchanged", pc_out, 32'h0000_1000);

    // jisr with eret in IDLE.
    drain_done = 1'b1; eret = 1'b1; jisr = 1'b1;
    tick();
    check("jisr_idle_ignored", 32'(flags), 32'(F_IDLE));
    eret = 1'b0; jisr = 1'b0;

    // jisr in DRAIN aborts without writes.
    drain_done = 1'b0; eret = 1'b1;
    tick();
    check("jisr_drain_entry", 32'(flags), 32'(F_BUSY));
    eret = 1'b0; jisr = 1'b1;
    tick();
    check("jisr_drain_abort", 32'(flags), 32'(F_IDLE));
    jisr = 1'b0; drain_done = 1'b1;
    tick();
    check("jisr_drain_no_write", 32'(flags), 32'(F_IDLE));

    // jisr in RESTORE: writes happen, GUARD is skipped.
    esr_in = 32'hA5A5_0000; epc_in = 32'h0000_4000; emode_in = 1'b0; eret = 1'b1;
    tick();
    check("jisr_rst_drain", 32'(flags), 32'(F_BUSY));
    eret = 1'b0;
    tick();
    check("jisr_rst_restore", 32'(flags), 32'(F_RESTORE));
    check("jisr_rst_sr_out", sr_out, 32'hA5A5_0000);
    check("jisr_rst_pc_out", pc_out, 32'h0000_4000);
    check("jisr_rst_mode_out", 32'(mode_out), 32'h0);
    jisr = 1'b1;
    tick();
    check("jisr_rst_idle", 32'(flags), 32'(F_IDLE));
    jisr = 1'b0;

    // Reset while draining with drain_done high.
    esr_in = 32'h1234_5678; epc_in = 32'h0000_5000; emode_in = 1'b1; eret = 1'b1;
    tick();
    check("rst_mid_drain", 32'(flags), 32'(F_BUSY));
    eret = 1'b0; reset = 1'b1;
    tick();
    check("rst_mid_flags", 32'(flags), 32'(F_IDLE));
    check("rst_mid_sr_out", sr_out, 32'h0);
    check("rst_mid_pc_out", pc_out, 32'h0);
    reset = 1'b0;
    tick();
    check("rst_mid_no_strobe", 32'(flags), 32'(F_IDLE));
    eret = 1'b1;
    tick();
    check("rst_new_drain", 32'(flags), 32'(F_BUSY));
    eret = 1'b0;
    tick();
    check("rst_new_restore", 32'(flags), 32'(F_RESTORE));
    check("rst_new_sr_out", sr_out, 32'h1234_5678);
    check("rst_new_pc_out", pc_out, 32'h0000_5000);
    check("rst_new_mode_out", 32'(mode_out), 32'h1);
    tick();
    tick();
    check("rst_new_guard1", 32'(flags), 32'(F_BUSY));
    tick();
    check("rst_new_done", 32'(flags), 32'(F_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
